// File: rtl/rf_scoreboard_pkg.sv
// Shared definitions for the decode-stage register file: reg-0 index and the
// write-to-read bypass match helper.
package rf_pkg;

    localparam int unsigned REG0_IDX = 0;

    // True when a read port should take the in-flight writeback instead of storage.
    function automatic logic bypass_hit(
        input logic        bypassEn,
        input logic        wr,
        input int unsigned wsel,
        input int unsigned rsel
    );
        return bypassEn && wr && (wsel == rsel);
    endfunction

endpackage

// File: rtl/rf_scoreboard_dffr_n.sv
// Generic flop bank with synchronous active-low reset and load enable.
module dffr_n #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/rf_scoreboard.sv
// Parametrised two-read/one-write register file with bypass, optional zero
// register, per-register busy scoreboard and sticky error flag.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int SELW     = $clog2(DEPTH),
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SELW-1:0]  read1regsel,
    input  logic [SELW-1:0]  read2regsel,
    output logic [WIDTH-1:0] read1data,
    output logic [WIDTH-1:0] read2data,
    output logic             read1busy,
    output logic             read2busy,
    input  logic [SELW-1:0]  writeregsel,
    input  logic [WIDTH-1:0] writedata,
    input  logic             write,
    input  logic [SELW-1:0]  rsvregsel,
    input  logic             rsv,
    output logic             err
);

    logic [WIDTH-1:0]      regQ [DEPTH];
    logic [DEPTH-1:0]      busyQ;
    logic [DEPTH-1:0]      busyD;
    logic                  errQ;
    logic                  errD;
    logic                  wrEn;
    logic                  rsvEn;
    logic                  errSet;
    logic [SELW-1:0]       rdSel [2];
    logic [1:0][WIDTH:0]   rdOut;

    function automatic logic selOk(input logic [SELW-1:0] s);
        return int'({1'b0, s}) < DEPTH;
    endfunction

    function automatic logic isReg0(input logic [SELW-1:0] s);
        return ZERO_REG && (int'({1'b0, s}) == int'(REG0_IDX));
    endfunction

    // Returns {busy, data} for one read port; out-of-range selects read as idle zero.
    function automatic logic [WIDTH:0] readMux(
        input logic [SELW-1:0]  sel,
        input logic [WIDTH-1:0] regVal,
        input logic             busyVal,
        input logic             wr,
        input logic [SELW-1:0]  wsel,
        input logic [WIDTH-1:0] wdata
    );
        logic [WIDTH-1:0] data;
        logic             busy;
        data = '0;
        busy = 1'b0;
        if (selOk(sel)) begin
            data = regVal;
            busy = busyVal;
            if (bypass_hit(BYPASS, wr, int'({1'b0, wsel}), int'({1'b0, sel}))) begin
                data = wdata;
                busy = 1'b0;
            end
            if (isReg0(sel)) begin
                data = '0;
                busy = 1'b0;
            end
        end
        return {busy, data};
    endfunction

    assign wrEn  = write && selOk(writeregsel) && !isReg0(writeregsel);
    assign rsvEn = rsv && selOk(rsvregsel) && !isReg0(rsvregsel);

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        dffr_n #(.WIDTH(WIDTH)) u_reg (
            .clk_i  (clk),
            .rst_ni (rst),
            .en_i   (wrEn && (int'({1'b0, writeregsel}) == i)),
            .d_i    (writedata),
            .q_o    (regQ[i])
        );
    end

    // A reservation landing with a writeback to the same register wins: new producer.
    always_comb begin
        busyD = busyQ;
        if (wrEn) begin
            busyD[writeregsel] = 1'b0;
        end
        if (rsvEn) begin
            busyD[rsvregsel] = 1'b1;
        end
        if (ZERO_REG) begin
            busyD[REG0_IDX] = 1'b0;
        end
    end

    dffr_n #(.WIDTH(DEPTH)) u_busy (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (1'b1),
        .d_i    (busyD),
        .q_o    (busyQ)
    );

    always_comb begin
        errSet = 1'b0;
        if (write && !selOk(writeregsel)) errSet = 1'b1;
        if (rsv && !selOk(rsvregsel)) errSet = 1'b1;
        if (!selOk(read1regsel) || !selOk(read2regsel)) errSet = 1'b1;
        if (rsvEn && busyQ[rsvregsel] && !(wrEn && (writeregsel == rsvregsel))) begin
            errSet = 1'b1;
        end
        errD = errQ | errSet;
    end

    dffr_n #(.WIDTH(1)) u_err (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (1'b1),
        .d_i    (errD),
        .q_o    (errQ)
    );

    assign rdSel[0] = read1regsel;
    assign rdSel[1] = read2regsel;

    for (genvar p = 0; p < 2; p++) begin : g_read
        assign rdOut[p] = readMux(rdSel[p], regQ[rdSel[p]], busyQ[rdSel[p]],
                                  write, writeregsel, writedata);
    end

    assign read1data = rdOut[0][WIDTH-1:0];
    assign read1busy = rdOut[0][WIDTH];
    assign read2data = rdOut[1][WIDTH-1:0];
    assign read2busy = rdOut[1][WIDTH];
    assign err       = errQ;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: four configurations share one input bus
// (bypass, no bypass, DEPTH=6, zero register) and are checked per scenario.
module tb_rf_scoreboard;

    logic        clk;
    logic        rst;
    logic [2:0]  r1sel, r2sel, wsel, rsel;
    logic [15:0] wdata;
    logic        write, rsv;

    logic [15:0] d1 [4];
    logic [15:0] d2 [4];
    logic        b1 [4];
    logic        b2 [4];
    logic        e  [4];

    int errors = 0;
    int checks = 0;

    rf_scoreboard #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_byp (
        .clk(clk), .rst(rst), .read1regsel(r1sel), .read2regsel(r2sel),
        .read1data(d1[0]), .read2data(d2[0]), .read1busy(b1[0]), .read2busy(b2[0]),
        .writeregsel(wsel), .writedata(wdata), .write(write),
        .rsvregsel(rsel), .rsv(rsv), .err(e[0]));

    rf_scoreboard #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b0), .ZERO_REG(1'b0)) u_nobyp (
        .clk(clk), .rst(rst), .read1regsel(r1sel), .read2regsel(r2sel),
        .read1data(d1[1]), .read2data(d2[1]), .read1busy(b1[1]), .read2busy(b2[1]),
        .writeregsel(wsel), .writedata(wdata), .write(write),
        .rsvregsel(rsel), .rsv(rsv), .err(e[1]));

    rf_scoreboard #(.WIDTH(16), .DEPTH(6), .BYPASS(1'b1), .ZERO_REG(1'b0)) u_d6 (
        .clk(clk), .rst(rst), .read1regsel(r1sel), .read2regsel(r2sel),
        .read1data(d1[2]), .read2data(d2[2]), .read1busy(b1[2]), .read2busy(b2[2]),
        .writeregsel(wsel), .writedata(wdata), .write(write),
        .rsvregsel(rsel), .rsv(rsv), .err(e[2]));

    rf_scoreboard #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_zero (
        .clk(clk), .rst(rst), .read1regsel(r1sel), .read2regsel(r2sel),
        .read1data(d1[3]), .read2data(d2[3]), .read1busy(b1[3]), .read2busy(b2[3]),
        .writeregsel(wsel), .writedata(wdata), .write(write),
        .rsvregsel(rsel), .rsv(rsv), .err(e[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write = 1'b0;
        rsv   = 1'b0;
        wsel  = '0;
        rsel  = '0;
        wdata = '0;
    endtask

    task automatic doReset();
        idle();
        r1sel = '0;
        r2sel = '0;
        rst   = 1'b0;
        step();
        rst   = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        r1sel = 3'd3;
        r2sel = 3'd3;
        rst   = 1'b0;
        write = 1'b1;
        wsel  = 3'd3;
        wdata = 16'hAAAA;
        step();
        rst = 1'b1;
        idle();
        #1;
        checks++; if (d1[0] !== 16'h0) begin errors++; $display("FAIL reset_r1data: got %h want 0000", d1[0]); end
        checks++; if (d2[1] !== 16'h0) begin errors++; $display("FAIL reset_r2data_nobyp: got %h want 0000", d2[1]); end
        checks++; if (b1[0] !== 1'b0) begin errors++; $display("FAIL reset_r1busy: got %b want 0", b1[0]); end
        checks++; if (e[0] !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", e[0]); end
    endtask

    task automatic test_bypass();
        doReset();
        r1sel = 3'd5;
        write = 1'b1;
        wsel  = 3'd5;
        wdata = 16'hBEEF;
        #1;
        checks++; if (d1[0] !== 16'hBEEF) begin errors++; $display("FAIL bypass_same_cycle: got %h want beef", d1[0]); end
        checks++; if (d1[1] !== 16'h0000) begin errors++; $display("FAIL nobypass_before_edge: got %h want 0000", d1[1]); end
        step();
        idle();
        #1;
        checks++; if (d1[0] !== 16'hBEEF) begin errors++; $display("FAIL bypass_after_edge: got %h want beef", d1[0]); end
        checks++; if (d1[1] !== 16'hBEEF) begin errors++; $display("FAIL nobypass_after_edge: got %h want beef", d1[1]); end
    endtask

    task automatic test_scoreboard();
        doReset();
        rsv  = 1'b1;
        rsel = 3'd2;
        step();
        idle();
        r2sel = 3'd2;
        #1;
        checks++; if (b2[0] !== 1'b1) begin errors++; $display("FAIL rsv_busy: got %b want 1", b2[0]); end
        write = 1'b1;
        wsel  = 3'd2;
        wdata = 16'h0042;
        #1;
        checks++; if (b2[0] !== 1'b0) begin errors++; $display("FAIL wb_busy_bypass: got %b want 0", b2[0]); end
        checks++; if (d2[0] !== 16'h0042) begin errors++; $display("FAIL wb_data_bypass: got %h want 0042", d2[0]); end
        checks++; if (b2[1] !== 1'b1) begin errors++; $display("FAIL wb_busy_nobyp: got %b want 1", b2[1]); end
        step();
        idle();
        #1;
        checks++; if (b2[1] !== 1'b0) begin errors++; $display("FAIL wb_busy_cleared: got %b want 0", b2[1]); end
        checks++; if (d2[1] !== 16'h0042) begin errors++; $display("FAIL wb_data_stored: got %h want 0042", d2[1]); end
        checks++; if (e[0] !== 1'b0) begin errors++; $display("FAIL wb_err: got %b want 0", e[0]); end
    endtask

    task automatic test_double_rsv();
        doReset();
        write = 1'b1;
        wsel  = 3'd4;
        wdata = 16'h1234;
        rsv   = 1'b1;
        rsel  = 3'd4;
        step();
        idle();
        r1sel = 3'd4;
        #1;
        checks++; if (b1[0] !== 1'b1) begin errors++; $display("FAIL simul_busy: got %b want 1", b1[0]); end
        checks++; if (d1[0] !== 16'h1234) begin errors++; $display("FAIL simul_data: got %h want 1234", d1[0]); end
        checks++; if (e[0] !== 1'b0) begin errors++; $display("FAIL simul_err: got %b want 0", e[0]); end
        rsv  = 1'b1;
        rsel = 3'd4;
        #1;
        checks++; if (e[0] !== 1'b0) begin errors++; $display("FAIL dbl_err_early: got %b want 0", e[0]); end
        step();
        idle();
        #1;
        checks++; if (e[0] !== 1'b1) begin errors++; $display("FAIL dbl_err: got %b want 1", e[0]); end
        step();
        step();
        checks++; if (e[0] !== 1'b1) begin errors++; $display("FAIL dbl_err_sticky: got %b want 1", e[0]); end
        doReset();
        checks++; if (e[0] !== 1'b0) begin errors++; $display("FAIL err_reset: got %b want 0", e[0]); end
    endtask

    task automatic test_reset_mid_rsv();
        doReset();
        rsv  = 1'b1;
        rsel = 3'd6;
        step();
        idle();
        r1sel = 3'd6;
        #1;
        checks++; if (b1[1] !== 1'b1) begin errors++; $display("FAIL midrsv_busy: got %b want 1", b1[1]); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        checks++; if (b1[1] !== 1'b0) begin errors++; $display("FAIL midrsv_cleared: got %b want 0", b1[1]); end
    endtask

    task automatic test_depth6();
        doReset();
        write = 1'b1;
        wsel  = 3'd1;
        wdata = 16'h5555;
        step();
        wsel  = 3'd7;
        wdata = 16'h9999;
        r1sel = 3'd1;
        #1;
        checks++; if (e[2] !== 1'b0) begin errors++; $display("FAIL d6_err_early: got %b want 0", e[2]); end
        step();
        idle();
        #1;
        checks++; if (d1[2] !== 16'h5555) begin errors++; $display("FAIL d6_contents: got %h want 5555", d1[2]); end
        checks++; if (e[2] !== 1'b1) begin errors++; $display("FAIL d6_wr_err: got %b want 1", e[2]); end
        checks++; if (e[0] !== 1'b0) begin errors++; $display("FAIL d8_wr7_err: got %b want 0", e[0]); end
        doReset();
        r1sel = 3'd6;
        write = 1'b1;
        wsel  = 3'd6;
        wdata = 16'h7777;
        #1;
        checks++; if (d1[2] !== 16'h0000) begin errors++; $display("FAIL d6_read6: got %h want 0000", d1[2]); end
        checks++; if (b1[2] !== 1'b0) begin errors++; $display("FAIL d6_busy6: got %b want 0", b1[2]); end
        checks++; if (d1[0] !== 16'h7777) begin errors++; $display("FAIL d8_bypass6: got %h want 7777", d1[0]); end
        step();
        idle();
        r1sel = 3'd0;
        #1;
        checks++; if (e[2] !== 1'b1) begin errors++; $display("FAIL d6_rd_err: got %b want 1", e[2]); end
    endtask

    task automatic test_zero_reg();
        doReset();
        write = 1'b1;
        wsel  = 3'd0;
        wdata = 16'hFFFF;
        rsv   = 1'b1;
        rsel  = 3'd0;
        r1sel = 3'd0;
        #1;
        checks++; if (d1[3] !== 16'h0000) begin errors++; $display("FAIL zero_bypass: got %h want 0000", d1[3]); end
        checks++; if (d1[0] !== 16'hFFFF) begin errors++; $display("FAIL nonzero_bypass: got %h want ffff", d1[0]); end
        step();
        idle();
        #1;
        checks++; if (d1[3] !== 16'h0000) begin errors++; $display("FAIL zero_data: got %h want 0000", d1[3]); end
        checks++; if (b1[3] !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", b1[3]); end
        checks++; if (e[3] !== 1'b0) begin errors++; $display("FAIL zero_err: got %b want 0", e[3]); end
        checks++; if (b1[0] !== 1'b1) begin errors++; $display("FAIL nonzero_busy: got %b want 1", b1[0]); end
    endtask

    initial begin
        idle();
        r1sel = '0;
        r2sel = '0;
        rst   = 1'b0;
        step();
        test_reset();
        test_bypass();
        test_scoreboard();
        test_double_rsv();
        test_reset_mid_rsv();
        test_depth6();
        test_zero_reg();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Parametrised register file for the pipelined processor: generalises the fixed 8×16 two-read/one-write file to configurable width and depth. Adds write-to-read bypass, an optional hardwired-zero register, a per-register busy scoreboard for hazard detection, and a sticky error flag. It sits in decode: reads source operands, reserves destinations at issue, and takes the writeback port.

## Interface
- WIDTH, 16, data width in bits
- DEPTH, 8, number of registers (≥2; need not be a power of two)
- SELW, $clog2(DEPTH), select width (derived; not overridden)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports
- ZERO_REG, 0, 1 = register 0 reads as 0, ignores writes, never busy

- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (the block has one clock; reset is synchronous and active-low)
- read1regsel  in  SELW  read port 1 select
- read2regsel  in  SELW  read port 2 select
- read1data  out  WIDTH  port 1 data
- read2data  out  WIDTH  port 2 data
- read1busy  out  1  selected register has an outstanding reservation
- read2busy  out  1  same, port 2
- writeregsel  in  SELW  write select
- writedata  in  WIDTH  write data
- write  in  1  write enable
- rsvregsel  in  SELW  reservation select
- rsv  in  1  reserve destination (set busy)
- err  out  1  sticky error

## Operation
- Storage: DEPTH×WIDTH registers plus a DEPTH-bit busy vector plus the err flop.
- Write: on a rising clk edge with rst=1, write=1 and writeregsel<DEPTH, reg[writeregsel] ← writedata. Busy[writeregsel] ← 0, unless a reservation of the same register occurs in the same cycle.
- Reserve: on an edge with rsv=1 and rsvregsel<DEPTH, busy[rsvregsel] ← 1.
- Simultaneous write and rsv to the same register: data is written and busy ends at 1, because the new producer wins.
- Read is combinational. readNdata = reg[sel].
  - If BYPASS=1, write=1 and writeregsel==sel, readNdata = writedata.
  - If sel≥DEPTH, readNdata = 0.
- readNbusy = busy[sel].
  - If BYPASS=1 and the same register is being written this cycle, readNbusy = 0.
  - If sel≥DEPTH, readNbusy = 0.
- ZERO_REG=1: reg 0 always reads 0 (bypass included), busy[0] is forced 0, and writes/reservations of reg 0 are silently dropped (not errors).
- err is set on the edge after any of the following, and cleared only by reset:
  - write or rsv with sel≥DEPTH;
  - read select ≥DEPTH on either port;
  - rsv of a register already busy that is not being written in the same cycle (double reservation).
- rst=0 overrides all other activity on that edge.

## Timing
- Reset values after an edge with rst=0: all registers 0, busy all 0, err 0. Hence read1data = read2data = 0 and read1busy = read2busy = 0.
- Write-to-read latency: 0 cycles with BYPASS=1; 1 cycle (visible after the edge) with BYPASS=0.
- Reserve-to-busy latency: 1 cycle.
- err asserts 1 cycle after the offending inputs.
- Reset asserted mid-reservation clears busy bits. Outstanding writebacks after reset land normally.
- Outputs depend only on state and the current select/write inputs. There is no combinational path from rsv.

## Structure
- Package rf_pkg: the bypass-select helper function and the localparam for reg-0 index.
- Sub-module dffr_n: WIDTH-parametrised flop with synchronous active-low reset and enable. It is instantiated per register, for the busy vector, and for err.
- Read port logic is a generate loop over 2 ports sharing one mux function.

## Test plan
- Reset: hold rst=0 one edge with write=1 to reg 3 → all reads 0, busy 0, err 0.
- Write/bypass: BYPASS=1, write reg 5=16'hBEEF, read1regsel=5 in the same cycle → read1data=16'hBEEF before the edge and still after. With BYPASS=0, the old value 0 shows until the edge.
- Scoreboard: rsv reg 2, then next cycle read2regsel=2 → read2busy=1. Write reg 2 = 16'h0042 → read2busy=0 in the same cycle (BYPASS=1) and data=16'h0042.
- Simultaneous write and rsv reg 4 → busy[4]=1 after the edge and reg 4 holds new data. A second rsv of reg 4 with no write → err=1 next cycle and stays 1 until reset.
- DEPTH=6: write to sel 7 → register contents unchanged, err=1 next cycle. Read sel 6 → data 0.
- ZERO_REG=1: write reg 0 = 16'hFFFF and rsv reg 0 → read 0, busy 0, err 0.
